// File: rtl/pla_truth_table_sweeper.sv
// Sweeps every input vector of a single-output combinational function block in
// ascending order, packs the sampled outputs into truth-table words, streams the
// words out on a valid/ready interface and counts the on-set of the function.
module pla_truth_table_sweeper #(
    parameter  int N_IN   = 8,
    parameter  int WORD_W = 32,
    localparam int NWORDS = (1 << N_IN) / WORD_W,
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int CNT_W  = N_IN + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   x,
    input  logic              y,
    output logic [WORD_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  onset_count,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FLUSH,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WORD_W-1:0] shift_word;
    logic [WORD_W-1:0] word_next;
    logic [BIT_W-1:0]  bit_idx;
    logic              start_ok;
    logic              stall;
    logic              accept;
    logic              capture;
    logic              word_end;
    logic              last_vec;

    // The low bits of x select the bit position inside the word being built.
    assign bit_idx  = x[BIT_W-1:0];
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign stall    = out_valid && !out_ready;
    assign accept   = out_valid && out_ready;
    assign capture  = (state == SWEEP) && !stall;
    assign word_end = capture && (bit_idx == {BIT_W{1'b1}});
    assign last_vec = capture && (x == {N_IN{1'b1}});

    // Current word with this cycle's function output merged into its slot.
    always_comb begin
        word_next          = shift_word;
        word_next[bit_idx] = y;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs derived from the state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (last_vec) state_next = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (accept) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) state_next = SWEEP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Vector counter, partial word and on-set counter advance once per unstalled capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            shift_word  <= '0;
            onset_count <= '0;
        end else if (start_ok) begin
            x           <= '0;
            shift_word  <= '0;
            onset_count <= '0;
        end else if (capture) begin
            x           <= x + N_IN'(1);
            onset_count <= onset_count + CNT_W'(y);
            shift_word  <= word_end ? '0 : word_next;
        end
    end

    // Output word register: load on word completion, otherwise drop valid once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
        end else if (word_end) begin
            out_data  <= word_next;
            out_index <= IDX_W'(x >> BIT_W);
            out_valid <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pla_truth_table_sweeper.sv
// Directed bench for the truth-table sweeper: a small behavioural function block
// drives y from x, a monitor records every accepted word, and table-driven
// sweeps plus hand-written stall/reset/restart sequences check the results.
module tb_pla_truth_table_sweeper;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  x;
    logic        y;
    logic [31:0] out_data;
    logic [2:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  onset_count;
    logic        busy;
    logic        done;

    logic [2:0]  mode;

    int n_checks;
    int n_fail;

    logic [31:0] got_data[$];
    logic [2:0]  got_index[$];

    typedef struct packed {
        logic [2:0]       mode;
        logic             stall_en;
        logic             mid_start;
        logic [8:0]       exp_onset;
        logic [7:0][31:0] exp_words;
    } vec_t;

    vec_t vecs[6];

    pla_truth_table_sweeper #(
        .N_IN   (8),
        .WORD_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x           (x),
        .y           (y),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .onset_count (onset_count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the PLA function block under extraction.
    always_comb begin
        case (mode)
            3'd1:    y = x[0];
            3'd2:    y = &x;
            3'd3:    y = x[5];
            3'd4:    y = x[7];
            default: y = 1'b0;
        endcase
    end

    // Record each word the consumer accepts at the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_index.push_back(out_index);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int v);
        int cnt;
        int stall_left;
        bit stall_used;
        bit mid_used;
        int exp_lat;
        mode      = vecs[v].mode;
        out_ready = 1'b1;
        got_data.delete();
        got_index.delete();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        checkOutput("restart_onset", 64'(onset_count), 64'(0));
        checkOutput("restart_x", 64'(x), 64'(0));
        checkOutput("restart_busy", 64'(busy), 64'(1));
        checkOutput("restart_done", 64'(done), 64'(0));
        cnt        = 0;
        stall_left = 0;
        stall_used = 1'b0;
        mid_used   = 1'b0;
        while (!done && cnt < 3000) begin
            if (start) start = 1'b0;
            if (vecs[v].mid_start && !mid_used && x == 8'd50) begin
                start    = 1'b1;
                mid_used = 1'b1;
            end
            if (stall_left > 0) begin
                checkOutput("stall_x", 64'(x), 64'(32));
                checkOutput("stall_valid", 64'(out_valid), 64'(1));
                checkOutput("stall_data", 64'(out_data), 64'(32'h0000_0000));
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end else if (vecs[v].stall_en && !stall_used && out_valid) begin
                out_ready  = 1'b0;
                stall_left = 10;
                stall_used = 1'b1;
            end
            @(posedge clk); #2;
            cnt++;
        end
        exp_lat = vecs[v].stall_en ? 267 : 257;
        checkOutput("done_reached", 64'(done), 64'(1));
        checkOutput("latency", 64'(cnt), 64'(exp_lat));
        checkOutput("onset_count", 64'(onset_count), 64'(vecs[v].exp_onset));
        checkOutput("word_count", 64'(got_data.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < got_data.size()) begin
                checkOutput($sformatf("word%0d_index", i), 64'(got_index[i]), 64'(i));
                checkOutput($sformatf("word%0d_data", i), 64'(got_data[i]), 64'(vecs[v].exp_words[i]));
            end
        end
        checkOutput("done_valid", 64'(out_valid), 64'(0));
        checkOutput("done_busy", 64'(busy), 64'(0));
        checkOutput("done_x", 64'(x), 64'(0));
        repeat (3) @(posedge clk);
        #2;
        checkOutput("hold_done", 64'(done), 64'(1));
        checkOutput("hold_onset", 64'(onset_count), 64'(vecs[v].exp_onset));
        checkOutput("hold_data", 64'(out_data), 64'(vecs[v].exp_words[7]));
        checkOutput("hold_index", 64'(out_index), 64'(7));
        checkOutput("hold_words", 64'(got_data.size()), 64'(8));
    endtask

    initial begin
        int cnt;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        mode      = 3'd0;

        // Hand-computed golden truth tables for each function.
        vecs[0].mode = 3'd0; vecs[0].stall_en = 1'b0; vecs[0].mid_start = 1'b0;
        vecs[0].exp_onset = 9'd0;   vecs[0].exp_words = {8{32'h0000_0000}};
        vecs[1].mode = 3'd1; vecs[1].stall_en = 1'b0; vecs[1].mid_start = 1'b0;
        vecs[1].exp_onset = 9'd128; vecs[1].exp_words = {8{32'hAAAA_AAAA}};
        vecs[2].mode = 3'd2; vecs[2].stall_en = 1'b0; vecs[2].mid_start = 1'b0;
        vecs[2].exp_onset = 9'd1;   vecs[2].exp_words = {32'h8000_0000, {7{32'h0000_0000}}};
        vecs[3].mode = 3'd3; vecs[3].stall_en = 1'b1; vecs[3].mid_start = 1'b0;
        vecs[3].exp_onset = 9'd128; vecs[3].exp_words = {4{32'hFFFF_FFFF, 32'h0000_0000}};
        vecs[4].mode = 3'd1; vecs[4].stall_en = 1'b0; vecs[4].mid_start = 1'b1;
        vecs[4].exp_onset = 9'd128; vecs[4].exp_words = {8{32'hAAAA_AAAA}};
        vecs[5].mode = 3'd4; vecs[5].stall_en = 1'b0; vecs[5].mid_start = 1'b0;
        vecs[5].exp_onset = 9'd128; vecs[5].exp_words = {{4{32'hFFFF_FFFF}}, {4{32'h0000_0000}}};

        #12;
        checkOutput("reset_x", 64'(x), 64'(0));
        checkOutput("reset_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_data", 64'(out_data), 64'(0));
        checkOutput("reset_index", 64'(out_index), 64'(0));
        checkOutput("reset_onset", 64'(onset_count), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        @(posedge clk); #2;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(v);
        end

        // Reset in the middle of a sweep.
        mode = 3'd1;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cnt = 0;
        while (x != 8'd100 && cnt < 400) begin
            @(posedge clk); #2;
            cnt++;
        end
        checkOutput("reached_x100", 64'(x), 64'(100));
        rst = 1'b1;
        #1;
        checkOutput("midrst_x", 64'(x), 64'(0));
        checkOutput("midrst_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_onset", 64'(onset_count), 64'(0));
        @(posedge clk); #2;
        rst = 1'b0;
        got_data.delete();
        got_index.delete();
        repeat (5) @(posedge clk);
        #2;
        checkOutput("postrst_valid", 64'(out_valid), 64'(0));
        checkOutput("postrst_busy", 64'(busy), 64'(0));
        checkOutput("postrst_words", 64'(got_data.size()), 64'(0));
        checkOutput("postrst_x", 64'(x), 64'(0));

        applyStimulus(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
